// File: rtl/udp_tx_packer_pkg.sv
// rtl/udp_tx_packer_pkg.sv - shared state encoding and defaults for the UDP tx packer
package udp_tx_packer_pkg;

  // Packer control states; START lasts exactly one cycle
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } pk_state_t;

  localparam int DEF_BUF_AW      = 11;
  localparam int DEF_PKT_BYTES   = 1024;
  localparam int DEF_TIMEOUT_CYC = 50000;

  // Idle counter width; keeps at least one bit when the timeout is disabled
  function automatic int idle_width(input int timeout_cyc);
    return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/udp_tx_buf_ram.sv
// rtl/udp_tx_buf_ram.sv - byte packet buffer with separate write/read addresses and registered read
module udp_tx_buf_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  // Storage write; contents are never reset, only the counters around them
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; a same-edge write to the read address is forwarded so a
  // one-byte datagram sees its own byte when the flush read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_packer.sv
// rtl/udp_tx_packer.sv - collects user bytes into a buffer and feeds them to the UDP transmitter
module udp_tx_packer
  import udp_tx_packer_pkg::*;
#(
  parameter int BUF_AW      = DEF_BUF_AW,
  parameter int PKT_BYTES   = DEF_PKT_BYTES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        eth_tx_clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        ovf_drop
);

  localparam int CW     = BUF_AW + 1;
  localparam int IDLE_W = idle_width(TIMEOUT_CYC);
  localparam logic [CW-1:0]     PKT_LIM   = CW'(PKT_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYC > 0) ? IDLE_W'(TIMEOUT_CYC - 1) : '0;

  pk_state_t         state, state_nxt;
  logic [CW-1:0]     wr_cnt, rd_ptr, wr_cnt_inc;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept, timeout_hit, flush_now, rd_at_end, rd_en;
  logic [BUF_AW-1:0] rd_addr;

  assign accept      = in_valid && in_ready;
  assign wr_cnt_inc  = wr_cnt + CW'(1);
  assign timeout_hit = (TIMEOUT_CYC != 0) && !accept && (wr_cnt != '0) && (idle_cnt == IDLE_LAST);
  // Threshold, in_last and timeout all collapse into one flush decision
  assign flush_now   = (accept && ((wr_cnt_inc == PKT_LIM) || in_last)) || timeout_hit;
  assign rd_at_end   = (16'(rd_ptr) == tx_byte_num);

  // State register
  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // Next-state decision; tx_done is honoured only once a datagram is being read out
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (flush_now) state_nxt = ST_START;
      ST_START: state_nxt = ST_SEND;
      ST_SEND:  begin
        if (tx_done)        state_nxt = ST_FILL;
        else if (rd_at_end) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (tx_done) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // State-decoded outputs and buffer read control
  always_comb begin
    in_ready = (state == ST_FILL);
    busy     = (state != ST_FILL);
    ovf_drop = in_valid && (state != ST_FILL);
    rd_en    = 1'b0;
    rd_addr  = '0;
    if (state == ST_FILL && flush_now) begin
      rd_en = 1'b1;                         // pre-load byte 0 for the START cycle
    end else if (state == ST_SEND && tx_req && !rd_at_end) begin
      rd_en   = 1'b1;
      rd_addr = rd_ptr[BUF_AW-1:0];
    end
  end

  // Fill/read counters, idle timer and the registered start handshake
  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      idle_cnt    <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
    end else begin
      tx_start_en <= 1'b0;
      case (state)
        ST_FILL: begin
          if (accept) begin
            wr_cnt   <= wr_cnt_inc;
            idle_cnt <= '0;
          end else if ((wr_cnt != '0) && (idle_cnt != '1)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
          if (flush_now) begin
            tx_start_en <= 1'b1;
            tx_byte_num <= 16'(accept ? wr_cnt_inc : wr_cnt);
            rd_ptr      <= CW'(1);
          end
        end
        ST_SEND: begin
          if (rd_en) rd_ptr <= rd_ptr + CW'(1);
          if (tx_done) begin
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            idle_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            idle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  udp_tx_buf_ram #(.AW(BUF_AW)) u_buf (
    .clk     (eth_tx_clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (wr_cnt[BUF_AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (tx_data)
  );

endmodule

// File: tb/tb_udp_tx_packer.sv
// tb/tb_udp_tx_packer.sv - directed self-checking bench for udp_tx_packer
module tb_udp_tx_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  in_data;
  logic        tx_start_en, tx_req, tx_done, busy, ovf_drop;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data;

  int total  = 0;
  int passed = 0;
  int cyc, pulses;

  udp_tx_packer #(.BUF_AW(5), .PKT_BYTES(16), .TIMEOUT_CYC(100)) dut (
    .eth_tx_clk  (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .ovf_drop    (ovf_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_dgram();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; tx_req = 0; tx_done = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", tx_start_en, 0);
    chk("rst_byte_num", tx_byte_num, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_drop, 0);
    rst = 1'b0;
    tick();

    // Threshold flush: 16 back-to-back bytes, requests with one-cycle gaps
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    chk("thr_start", tx_start_en, 1);
    chk("thr_num", tx_byte_num, 16);
    chk("thr_data0", tx_data, 8'h00);
    chk("thr_ready_lo", in_ready, 0);
    tick();
    chk("thr_single_pulse", tx_start_en, 0);
    for (int i = 1; i < 16; i++) begin
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      chk("thr_data", tx_data, 16'(i));
      tick();
      chk("thr_hold", tx_data, 16'(i));
    end
    chk("thr_num_held", tx_byte_num, 16);
    chk("thr_ready_wait", in_ready, 0);
    tx_done = 1'b1; #1;
    chk("thr_ready_done_cyc", in_ready, 0);
    tick(); tx_done = 1'b0;
    chk("thr_ready_back", in_ready, 1);
    chk("thr_busy_clr", busy, 0);

    // in_last flush
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("last_start", tx_start_en, 1);
    chk("last_num", tx_byte_num, 2);
    chk("last_data0", tx_data, 8'hA5);
    tick();
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    chk("last_data1", tx_data, 8'h5A);
    finish_dgram();

    // Empty buffer must never time out
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx_start_en) pulses++;
    end
    chk("empty_no_start", 16'(pulses), 0);

    // Timeout flush: start exactly 100 cycles after the last accepted byte
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    cyc = 0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (tx_start_en) break;
    end
    chk("to_latency", 16'(cyc), 100);
    chk("to_num", tx_byte_num, 3);
    chk("to_data0", tx_data, 8'h01);
    tick();
    tx_req = 1'b1; tick(); tick(); tx_req = 1'b0;
    chk("to_data2", tx_data, 8'h03);
    finish_dgram();

    // Overflow: bytes presented while busy are dropped one pulse per cycle
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    in_valid = 1'b1; in_data = 8'hEE;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ovf_drop) pulses++;
      tick();
    end
    in_valid = 1'b0; #1;
    chk("ovf_pulses", 16'(pulses), 6);
    chk("ovf_idle", ovf_drop, 0);
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    chk("ovf_data1", tx_data, 8'h22);
    finish_dgram();
    send_byte(8'h33, 1'b1);
    chk("ovf_next_num", tx_byte_num, 1);
    chk("ovf_next_data", tx_data, 8'h33);
    tick(); tick();
    finish_dgram();

    // Reset in the middle of SEND
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_req = 1'b0;
    chk("rs_data5", tx_data, 8'h45);
    rst = 1'b1; #1;
    chk("rs_in_ready", in_ready, 1);
    chk("rs_start", tx_start_en, 0);
    chk("rs_num", tx_byte_num, 0);
    chk("rs_data", tx_data, 0);
    chk("rs_busy", busy, 0);
    tick(); tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_start_en) pulses++;
    end
    chk("rs_no_start", 16'(pulses), 0);
    for (int i = 0; i < 4; i++) send_byte(8'h71 + 8'(i), i == 3);
    chk("rs_new_num", tx_byte_num, 4);
    chk("rs_new_d0", tx_data, 8'h71);
    tick();
    for (int i = 1; i < 4; i++) begin
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      chk("rs_new_d", tx_data, 16'(8'h71 + 8'(i)));
    end
    finish_dgram();

    // Over-request: 20 requests on a 16-byte datagram
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    chk("or_num", tx_byte_num, 16);
    tick();
    tx_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("or_data", tx_data, (k < 15) ? 16'(k) : 16'h0F);
    end
    tx_req = 1'b0;
    finish_dgram();
    chk("or_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
